// File: rtl/board_io_pkg.sv
// board_io_pkg: reset FSM states and DBG bus field layout.
// Shared by board_io_ctrl, its debouncer and the bench.
package board_io_pkg;

  localparam int MAX_CH = 8;
  localparam int DBG_W  = 32;

  typedef enum logic [1:0] {
    ST_POR,
    ST_RUN,
    ST_ARMING,
    ST_HOLD
  } rst_state_e;

  // MCU -> board
  localparam int DIN_LED_LSB  = 0;
  localparam int DIN_LED_W    = MAX_CH;
  localparam int DIN_CLR_LSB  = 8;
  localparam int DIN_CLR_W    = MAX_CH;
  localparam int DIN_DUTY_LSB = 16;
  localparam int DIN_DUTY_W   = 4;

  // board -> MCU
  localparam int DOUT_SW_LSB   = 0;
  localparam int DOUT_BTN_LSB  = 8;
  localparam int DOUT_FLAG_LSB = 16;
  localparam int DOUT_FLD_W    = MAX_CH;

endpackage

// File: rtl/board_io_if.sv
// board_io_if: 32-bit debug port pair between MCU and board I/O.
// master = MCU side, slave = board_io_ctrl side.
interface board_io_if;
  import board_io_pkg::*;

  logic [DBG_W-1:0] DBG_FROM_MCU_I;
  logic [DBG_W-1:0] DBG_TO_MCU_O;

  modport master (
    output DBG_FROM_MCU_I,
    input  DBG_TO_MCU_O
  );

  modport slave (
    input  DBG_FROM_MCU_I,
    output DBG_TO_MCU_O
  );
endinterface

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchroniser plus tick-based debounce for
// one raw input; stable moves only after DEBOUNCE_TICKS ticks.
module io_debounce #(
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_stable
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_stable;

  // bring the async pin into the clock domain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], i_raw};
  end

  // count ticks of disagreement; any agreement restarts the count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync[1] == r_stable) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;
endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: debounced buttons/switches, press flags, LEDs
// and MCU reset sequencing. Option: BOARD_IO_PWM_EN (LED PWM).
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int NUM_BTN          = 4,
  parameter int NUM_SW           = 4,
  parameter int NUM_LED          = 4,
  parameter int TICK_DIV         = 1250,
  parameter int DEBOUNCE_TICKS   = 10,
  parameter logic [NUM_BTN-1:0] RESET_MASK =
    NUM_BTN'(4'b0011),
  parameter int RESET_HOLD_TICKS = 100,
  parameter int RESET_STRETCH    = 16
) (
  input  logic               CLK,
  input  logic               RESET_N_I,
  input  logic [NUM_BTN-1:0] BUTTONS_I,
  input  logic [NUM_SW-1:0]  SWITCHES_I,
  output logic [NUM_LED-1:0] LEDS_O,
  output logic               MCU_RESET_O,
  board_io_if.slave          dbg
);
  localparam int NUM_IN = NUM_BTN + NUM_SW;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW_W = $clog2(RESET_STRETCH + 1);
  localparam int HW = $clog2(RESET_HOLD_TICKS + 1);
  localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW_W-1:0] STR_LAST  =
    SW_W'(RESET_STRETCH - 1);
  localparam logic [HW-1:0]   HOLD_LAST =
    HW'(RESET_HOLD_TICKS - 1);

  logic [PW-1:0]      r_pre;
  logic               w_tick;
  logic [NUM_IN-1:0]  w_raw;
  logic [NUM_IN-1:0]  w_db;
  logic [NUM_BTN-1:0] w_btn_db;
  logic [NUM_SW-1:0]  w_sw_db;
  logic [NUM_BTN-1:0] w_clr;
  logic [NUM_BTN-1:0] r_btn_prev;
  logic [NUM_BTN-1:0] r_flags;
  logic [DBG_W-1:0]   r_dbg;
  logic               w_chord;
  rst_state_e         r_state;
  rst_state_e         w_state_nxt;
  logic [SW_W-1:0]    r_str;
  logic [SW_W-1:0]    w_str_nxt;
  logic [HW-1:0]      r_hold;
  logic [HW-1:0]      w_hold_nxt;
  logic               r_mcu_rst;
  logic [NUM_LED-1:0] w_led_req;
  logic [NUM_LED-1:0] r_leds;
  logic               w_unused;

  // bits of the MCU word this build does not look at
  assign w_unused = ^dbg.DBG_FROM_MCU_I;

  // debounce tick prescaler, wraps at TICK_DIV-1
  always_ff @(posedge CLK or negedge RESET_N_I) begin
    if (!RESET_N_I)  r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + PW'(1);
  end

  assign w_tick = (r_pre == PRE_LAST);

  assign w_raw = {SWITCHES_I, BUTTONS_I};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_db
    io_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_db (
      .i_clk   (CLK),
      .i_rst_n (RESET_N_I),
      .i_raw   (w_raw[g]),
      .i_tick  (w_tick),
      .o_stable(w_db[g])
    );
  end

  assign w_btn_db = w_db[NUM_BTN-1:0];
  assign w_sw_db  = w_db[NUM_IN-1:NUM_BTN];
  assign w_clr    = dbg.DBG_FROM_MCU_I[DIN_CLR_LSB +: NUM_BTN];

  // press flags: rising edge sets, MCU mask clears, set wins
  always_ff @(posedge CLK or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      r_btn_prev <= '0;
      r_flags    <= '0;
    end else begin
      r_btn_prev <= w_btn_db;
      r_flags    <= (w_btn_db & ~r_btn_prev) |
                    (r_flags & ~w_clr);
    end
  end

  // status word back to the MCU, unused field bits zero
  always_ff @(posedge CLK or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      r_dbg <= '0;
    end else begin
      r_dbg <= '0;
      r_dbg[DOUT_SW_LSB +: NUM_SW]    <= w_sw_db;
      r_dbg[DOUT_BTN_LSB +: NUM_BTN]  <= w_btn_db;
      r_dbg[DOUT_FLAG_LSB +: NUM_BTN] <= r_flags;
    end
  end

  assign dbg.DBG_TO_MCU_O = r_dbg;

  assign w_chord = (RESET_MASK != '0) &&
                   ((w_btn_db & RESET_MASK) == RESET_MASK);

  // reset sequencer state register
  always_ff @(posedge CLK or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      r_state   <= ST_POR;
      r_str     <= '0;
      r_hold    <= '0;
      r_mcu_rst <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_str     <= w_str_nxt;
      r_hold    <= w_hold_nxt;
      r_mcu_rst <= (w_state_nxt == ST_POR) ||
                   (w_state_nxt == ST_HOLD);
    end
  end

  // reset sequencer next state
  always_comb begin
    w_state_nxt = r_state;
    w_str_nxt   = r_str;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      ST_POR: begin
        if (r_str == STR_LAST) begin
          w_state_nxt = ST_RUN;
          w_str_nxt   = '0;
        end else begin
          w_str_nxt = r_str + SW_W'(1);
        end
      end
      ST_RUN: begin
        if (w_chord) begin
          w_state_nxt = ST_ARMING;
          w_hold_nxt  = '0;
        end
      end
      ST_ARMING: begin
        if (!w_chord) begin
          w_state_nxt = ST_RUN;
        end else if (w_tick) begin
          if (r_hold == HOLD_LAST) w_state_nxt = ST_HOLD;
          else w_hold_nxt = r_hold + HW'(1);
        end
      end
      ST_HOLD: begin
        if (!w_chord) begin
          w_state_nxt = ST_POR;
          w_str_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_POR;
    endcase
  end

  assign MCU_RESET_O = r_mcu_rst;

`ifdef BOARD_IO_PWM_EN
  logic [3:0]            r_pwm;
  logic [DIN_DUTY_W-1:0] w_duty;
  logic                  w_pwm_on;

  // free-running PWM phase
  always_ff @(posedge CLK or negedge RESET_N_I) begin
    if (!RESET_N_I) r_pwm <= '0;
    else            r_pwm <= r_pwm + 4'd1;
  end

  assign w_duty   = dbg.DBG_FROM_MCU_I[DIN_DUTY_LSB +: DIN_DUTY_W];
  assign w_pwm_on = (w_duty == 4'hF) || (r_pwm < w_duty);
  assign w_led_req =
    dbg.DBG_FROM_MCU_I[DIN_LED_LSB +: NUM_LED] &
    {NUM_LED{w_pwm_on}};
`else
  assign w_led_req = dbg.DBG_FROM_MCU_I[DIN_LED_LSB +: NUM_LED];
`endif

  // LED drive: dark in POR, all lit in HOLD, else MCU value
  always_ff @(posedge CLK or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      r_leds <= '0;
    end else begin
      unique case (1'b1)
        (w_state_nxt == ST_POR):  r_leds <= '0;
        (w_state_nxt == ST_HOLD): r_leds <= '1;
        default:                  r_leds <= w_led_req;
      endcase
    end
  end

  assign LEDS_O = r_leds;
endmodule
